// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
// APB completer that holds a DEPTH x DATA_WIDTH register file. It inserts
// WAIT_STATES cycles of pready=0 into every access phase and flags addresses
// at or above DEPTH with pslverr.
//
// Ports
//   PCLK     in   clock, rising edge
//   PRESET   in   asynchronous active-high reset
//   psel     in   completer select
//   penable  in   access-phase indicator
//   pwrite   in   1 = write, 0 = read
//   paddr    in   transfer address (ADDR_WIDTH)
//   pwdata   in   write data (DATA_WIDTH), sampled at the completion edge
//   prdata   out  read data, registered, valid while pready=1 on a read
//   pready   out  transfer-complete strobe, registered
//   pslverr  out  error response, registered, valid while pready=1
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no transfer; a setup phase latches address/direction
// S_WAIT   | access phase, pready=0, counting down the wait states
// S_ACCESS | access phase, pready=1, completes on psel & penable
// -----------------------------------------------------------------------------
module apb_slave_regfile #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr
);

   localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [2:0] {
      S_IDLE   = 3'b001,
      S_WAIT   = 3'b010,
      S_ACCESS = 3'b100
   } state_t;

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  dir_q;
   logic                  err_q;
   logic                  pready_q;
   logic                  pslverr_q;
   logic [DATA_WIDTH-1:0] prdata_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Decode of the live bus address (setup edge) and of the latched one
   // (end of wait states). Out-of-range reads return zero, so the array
   // index is only meaningful when the error flag is clear.
   logic                  err_d;
   logic [DATA_WIDTH-1:0] rd_setup_d;
   logic [DATA_WIDTH-1:0] rd_wait_d;

   assign err_d      = (32'(paddr) >= DEPTH);
   assign rd_setup_d = err_d ? '0 : mem_q[paddr[IDX_W-1:0]];
   assign rd_wait_d  = err_q ? '0 : mem_q[addr_q[IDX_W-1:0]];

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         dir_q     <= 1'b0;
         err_q     <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               pready_q  <= 1'b0;
               pslverr_q <= 1'b0;
               if (psel && !penable) begin
                  addr_q <= paddr;
                  dir_q  <= pwrite;
                  err_q  <= err_d;
                  if (WAIT_STATES == 0) begin
                     state_q   <= S_ACCESS;
                     pready_q  <= 1'b1;
                     pslverr_q <= err_d;
                     if (!pwrite) prdata_q <= rd_setup_d;
                  end else begin
                     state_q <= S_WAIT;
                     cnt_q   <= WS_LOAD;
                  end
               end
            end
            S_WAIT: begin
               if (!psel) begin
                  state_q   <= S_IDLE;
                  pready_q  <= 1'b0;
                  pslverr_q <= 1'b0;
               end else if (penable) begin
                  // The counter holds while penable is low with psel high.
                  if (cnt_q == 4'd0) begin
                     state_q   <= S_ACCESS;
                     pready_q  <= 1'b1;
                     pslverr_q <= err_q;
                     if (!dir_q) prdata_q <= rd_wait_d;
                  end else begin
                     cnt_q <= cnt_q - 4'd1;
                  end
               end
            end
            S_ACCESS: begin
               if (!psel) begin
                  state_q   <= S_IDLE;
                  pready_q  <= 1'b0;
                  pslverr_q <= 1'b0;
               end else if (penable) begin
                  if (dir_q && !err_q) mem_q[addr_q[IDX_W-1:0]] <= pwdata;
                  state_q   <= S_IDLE;
                  pready_q  <= 1'b0;
                  pslverr_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               pready_q  <= 1'b0;
               pslverr_q <= 1'b0;
            end
         endcase
      end
   end

   assign prdata  = prdata_q;
   assign pready  = pready_q;
   assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Two instances share clock and reset: one with no wait states, one with three.
module tb_apb_slave_regfile;

   localparam int DEPTH = 16;

   logic            PCLK = 1'b0;
   logic            PRESET;
   logic [1:0]      psel_v, penable_v, pwrite_v, pready_v, pslverr_v;
   logic [1:0][7:0] paddr_v, pwdata_v, prdata_v;

   int tests = 0;
   int fails = 0;

   logic [7:0] model [2][DEPTH];
   int         ws_of [2];

   always #5 PCLK = ~PCLK;

   apb_slave_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .psel    (psel_v[0]),
      .penable (penable_v[0]),
      .pwrite  (pwrite_v[0]),
      .paddr   (paddr_v[0]),
      .pwdata  (pwdata_v[0]),
      .prdata  (prdata_v[0]),
      .pready  (pready_v[0]),
      .pslverr (pslverr_v[0])
   );

   apb_slave_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(DEPTH), .WAIT_STATES(3)) u_dut1 (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .psel    (psel_v[1]),
      .penable (penable_v[1]),
      .pwrite  (pwrite_v[1]),
      .paddr   (paddr_v[1]),
      .pwdata  (pwdata_v[1]),
      .prdata  (prdata_v[1]),
      .pready  (pready_v[1]),
      .pslverr (pslverr_v[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   function automatic logic [7:0] exp_rd(input int d, input logic [7:0] addr);
      return (int'(addr) < DEPTH) ? model[d][int'(addr)] : 8'h00;
   endfunction

   task automatic bus_idle(input int d);
      psel_v[d]    = 1'b0;
      penable_v[d] = 1'b0;
   endtask

   // One APB transfer; optionally disturbs paddr/pwrite after the setup phase.
   task automatic xfer(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                       input bit chg, input logic [7:0] addr2,
                       output logic [7:0] rdata, output logic err, output int waits);
      psel_v[d]    = 1'b1;
      penable_v[d] = 1'b0;
      pwrite_v[d]  = wr;
      paddr_v[d]   = addr;
      pwdata_v[d]  = wdata;
      step();
      penable_v[d] = 1'b1;
      if (chg) begin
         paddr_v[d]  = addr2;
         pwrite_v[d] = ~wr;
      end
      waits = 0;
      while (pready_v[d] !== 1'b1 && waits < 40) begin
         waits++;
         step();
         if (chg) pwrite_v[d] = wr;
      end
      rdata = prdata_v[d];
      err   = pslverr_v[d];
      step();
      bus_idle(d);
   endtask

   // Transfer checked against the reference model.
   task automatic do_xfer(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                          input string tag);
      logic [7:0] rdata;
      logic       err;
      int         waits;
      logic [7:0] exp_data;
      exp_data = exp_rd(d, addr);
      xfer(d, wr, addr, wdata, 1'b0, 8'h00, rdata, err, waits);
      chk({tag, "_waits"}, 32'(waits), 32'(ws_of[d]));
      chk({tag, "_slverr"}, {31'b0, err}, {31'b0, int'(addr) >= DEPTH});
      if (!wr) chk({tag, "_rdata"}, {24'b0, rdata}, {24'b0, exp_data});
      chk({tag, "_pready_low"}, {31'b0, pready_v[d]}, 32'd0);
      if (wr && int'(addr) < DEPTH) model[d][int'(addr)] = wdata;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rdata;
      logic       err;
      int         waits;
      ws_of[0] = 0;
      ws_of[1] = 3;
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < DEPTH; a++) model[d][a] = 8'h00;

      PRESET    = 1'b1;
      psel_v    = '0;
      penable_v = '0;
      pwrite_v  = '0;
      paddr_v   = '0;
      pwdata_v  = '0;
      step();
      step();
      for (int d = 0; d < 2; d++) begin
         chk("reset_pready", {31'b0, pready_v[d]}, 32'd0);
         chk("reset_pslverr", {31'b0, pslverr_v[d]}, 32'd0);
         chk("reset_prdata", {24'b0, prdata_v[d]}, 32'd0);
      end
      PRESET = 1'b0;
      step();

      // Zero-wait and three-wait basic write/read
      do_xfer(0, 1'b1, 8'd3, 8'hA5, "w0_wr3");
      do_xfer(0, 1'b0, 8'd3, 8'h00, "w0_rd3");
      do_xfer(1, 1'b1, 8'd7, 8'h3C, "w3_wr7");
      do_xfer(1, 1'b0, 8'd7, 8'h00, "w3_rd7");

      // Out-of-range write and read
      for (int d = 0; d < 2; d++) begin
         do_xfer(d, 1'b1, 8'd16, 8'hFF, "oor_wr16");
         do_xfer(d, 1'b0, 8'd16, 8'h00, "oor_rd16");
         do_xfer(d, 1'b0, 8'd0, 8'h00, "oor_rd0");
         do_xfer(d, 1'b0, 8'd255, 8'h00, "oor_rd255");
      end

      // Back-to-back transfers with no idle cycles between them
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 3; i++) do_xfer(d, 1'b1, 8'(i), 8'(8'h11 * (i + 1)), "b2b_wr");
         for (int i = 0; i < 3; i++) do_xfer(d, 1'b0, 8'(i), 8'h00, "b2b_rd");
      end

      // Abort by dropping psel during WAIT
      psel_v[1] = 1'b1; penable_v[1] = 1'b0; pwrite_v[1] = 1'b1;
      paddr_v[1] = 8'd5; pwdata_v[1] = 8'h5A;
      step();
      penable_v[1] = 1'b1;
      step();
      bus_idle(1);
      step();
      chk("abort_wait_pready", {31'b0, pready_v[1]}, 32'd0);
      do_xfer(1, 1'b0, 8'd5, 8'h00, "abort_wait_rd5");

      // Abort by dropping psel in ACCESS on the zero-wait instance
      psel_v[0] = 1'b1; penable_v[0] = 1'b0; pwrite_v[0] = 1'b1;
      paddr_v[0] = 8'd5; pwdata_v[0] = 8'h6B;
      step();
      chk("abort_acc_pready_hi", {31'b0, pready_v[0]}, 32'd1);
      bus_idle(0);
      step();
      chk("abort_acc_pready", {31'b0, pready_v[0]}, 32'd0);
      do_xfer(0, 1'b0, 8'd5, 8'h00, "abort_acc_rd5");

      // Address and direction disturbed after setup
      xfer(1, 1'b1, 8'd4, 8'h77, 1'b1, 8'd9, rdata, err, waits);
      chk("chg_waits", 32'(waits), 32'd3);
      model[1][4] = 8'h77;
      do_xfer(1, 1'b0, 8'd4, 8'h00, "chg_rd4");
      do_xfer(1, 1'b0, 8'd9, 8'h00, "chg_rd9");

      // Randomized traffic against the model
      for (int n = 0; n < 80; n++) begin
         int  d;
         bit  wr;
         logic [7:0] a;
         d  = n % 2;
         wr = 1'($urandom_range(0, 1));
         a  = 8'($urandom_range(0, 19));
         do_xfer(d, wr, a, 8'($urandom), "rand");
         if ($urandom_range(0, 3) == 0) step();
      end

      // Reset asserted mid-ACCESS
      psel_v[1] = 1'b1; penable_v[1] = 1'b0; pwrite_v[1] = 1'b1;
      paddr_v[1] = 8'd2; pwdata_v[1] = 8'hEE;
      step();
      penable_v[1] = 1'b1;
      waits = 0;
      while (pready_v[1] !== 1'b1 && waits < 40) begin
         waits++;
         step();
      end
      chk("rst_mid_reached_access", {31'b0, pready_v[1]}, 32'd1);
      #2 PRESET = 1'b1;
      #1;
      chk("rst_async_pready", {31'b0, pready_v[1]}, 32'd0);
      bus_idle(1);
      step();
      PRESET = 1'b0;
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < DEPTH; a++) model[d][a] = 8'h00;
      step();
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < DEPTH; a++) do_xfer(d, 1'b0, 8'(a), 8'h00, "post_rst_rd");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB responder (completer) for the team's 8-bit APB master; sits at the far end of the psel/penable/pwrite/paddr bus.
- Holds a DEPTH x DATA_WIDTH register file and answers writes and reads.
- Inserts a programmable number of wait states through pready.
- Flags out-of-range addresses with pslverr.

Parameters:
- ADDR_WIDTH, 8, width of paddr.
- DATA_WIDTH, 8, width of pwdata/prdata and of each register.
- DEPTH, 16, number of registers; legal addresses are 0..DEPTH-1 (DEPTH <= 2^ADDR_WIDTH).
- WAIT_STATES, 0, access-phase cycles with pready=0 before completion; range 0..15 (4-bit counter).

Ports:
- PCLK  in  1  clock; all state updates on rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- psel  in  1  slave select from master.
- penable  in  1  access-phase indicator from master.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  transfer address.
- pwdata  in  DATA_WIDTH  write data.
- prdata  out  DATA_WIDTH  read data, registered, valid while pready=1 on a read.
- pready  out  1  transfer-complete strobe, registered.
- pslverr  out  1  error response, registered, valid only while pready=1.

Behaviour:
- Reset (PRESET=1, async): state=IDLE, wait counter=0, pready=0, pslverr=0, prdata=0, all registers=0, latched addr/dir=0. Reset asserted mid-transfer aborts the transfer; no register is modified by it.
- States: IDLE, WAIT, ACCESS (one-hot encoded).
- IDLE:
  - pready=0.
  - At an edge sampling psel=1 and penable=0 (setup phase), latch paddr and pwrite into internal address/direction registers and set err = (paddr >= DEPTH).
  - If WAIT_STATES==0, go to ACCESS, assign pready<=1 and pslverr<=err. On a read, assign prdata<=(err ? 0 : reg[addr]).
  - Otherwise go to WAIT, counter<=WAIT_STATES-1.
  - psel=0 keeps the block in IDLE.
- WAIT:
  - pready=0.
  - Each edge with psel=1 and penable=1: if counter==0, go to ACCESS with the same pready/pslverr/prdata loads as above; else counter decrements.
  - Total access-phase cycles with pready=0 is exactly WAIT_STATES.
- ACCESS:
  - pready=1.
  - At the edge sampling psel=1, penable=1, pready=1 (completion):
    - On a write with err=0, reg[latched addr]<=pwdata.
    - On a write with err=1, nothing is written.
    - Then pready<=0, pslverr<=0, go to IDLE.
  - prdata holds its last value after completion; it is not cleared.
- Back-to-back transfers: the master's next setup phase occurs in the cycle after completion and is accepted from IDLE. Zero-wait throughput is one transfer per 2 cycles.
- Protocol abort: psel sampled 0 while in WAIT or ACCESS → go to IDLE, pready<=0, pslverr<=0, no write.
- penable=0 while psel=1 in WAIT:
  - The counter holds.
  - Treat it as a new setup only from IDLE.
- Latched address/direction are used for the whole transfer; paddr/pwrite changes after setup are ignored. pwdata is sampled at the completion edge.
- Address decode uses the full ADDR_WIDTH bits; there is no aliasing and no wrap-around.

Test Plan:
- WAIT_STATES=0: write 0xA5 to addr 3, then read addr 3 → pready high in the first access cycle of each transfer, pslverr=0, prdata=0xA5; each transfer takes 2 cycles.
- WAIT_STATES=3: write 0x3C to addr 7 → pready low for exactly 3 access cycles, high on the 4th. A read of addr 7 returns 0x3C with the same timing.
- Out-of-range: write 0xFF to addr 16 (DEPTH=16), then read addr 16 → pslverr=1 coincident with pready on both transfers, read prdata=0, and reg[0..15] are unchanged (read addr 0 → 0x00).
- Back-to-back: writes of 0x11, 0x22, 0x33 to addrs 0, 1, 2 with no idle cycles, then reads of all three → returns 0x11, 0x22, 0x33; no transfer dropped.
- Abort and reset: psel dropped during WAIT of a write to addr 5 → next read of addr 5 returns 0x00. PRESET pulsed mid-ACCESS → pready=0 immediately (async), and all registers read back 0x00.
- Address change after setup: paddr changed from 4 to 9 during wait cycles of a write of 0x77 → reg[4]=0x77, reg[9]=0x00.
